// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fetch : PC, single-outstanding imem fetch, one-word decode buffer |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [5:0]  id_op,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lo;

  // Targets are always word aligned; the low bits of redirect_pc are dropped.
  assign redirect_tgt       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_tgt;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // A response in the same cycle is already stale, so no kill is needed.
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (!kill_q) begin
            buf_instr_d = imem_resp_data;
            buf_pc_d    = pc_q;
            state_d     = HOLD;
          end else begin
            kill_d  = 1'b0;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (id_ready) begin
          pc_d        = buf_pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_req_valid = (state_q == REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign id_valid       = (state_q == HOLD) && !redirect_valid;
  assign id_instr       = buf_instr_q;
  assign id_pc          = buf_pc_q;
  assign id_op          = buf_instr_q[31:26];
  assign fetch_cnt      = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifu_fetch : randomized bench for ifu_fetch with a transaction model |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, fetch_cnt;
  logic [5:0]  id_op;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_op(id_op), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // stimulus knobs
  int ready_pct = 0, idr_pct = 0, redir_pct = 0, stray_pct = 0;
  int lat_min = 1, lat_max = 1;
  bit force_redir = 0;
  logic [31:0] force_target = 32'd0;
  bit redir_on_resp = 0;
  logic [31:0] resp_target = 32'd0;

  // memory model and expected program-order state
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'd0;
  bit          late_ok  = 0;
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] exp_cnt  = 32'd0;
  bit          prev_hold = 0;
  logic [31:0] hold_instr, hold_pc;
  logic [31:0] pcs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic cycle();
    logic [31:0] w;
    @(posedge clk); #1;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    id_ready       = ($urandom_range(99) < idr_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_target; force_redir = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect_valid = 1'b1;
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        if (redir_on_resp) begin
          redirect_valid = 1'b1; redirect_pc = resp_target; redir_on_resp = 0;
        end
      end
      mem_cnt--;
    end else if ($urandom_range(99) < stray_pct) begin
      imem_resp_valid = 1'b1;
    end
    @(negedge clk);

    n_assert++;
    if (fetch_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, exp_cnt);
    end
    if (prev_hold && id_valid) begin
      n_assert++;
      if (id_instr !== hold_instr || id_pc !== hold_pc) begin
        n_fail++; $display("FAIL hold_stable: got %h@%h want %h@%h", id_instr, id_pc, hold_instr, hold_pc);
      end
    end
    if (redirect_valid) begin
      n_assert++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
        n_fail++; $display("FAIL redirect_priority: req_valid=%b id_valid=%b want 0 0", imem_req_valid, id_valid);
      end
    end
    if (imem_resp_valid && mem_busy) mem_busy = 0;
    if (imem_req_valid === 1'b1) begin
      if (!late_ok) begin
        n_assert++;
        if (mem_busy) begin
          n_fail++; $display("FAIL req_while_busy: req_valid=1 want 0 (addr %h)", imem_req_addr);
        end
      end
      n_assert++;
      if (imem_req_addr !== exp_pc) begin
        n_fail++; $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_pc);
      end
      if (imem_req_ready && !mem_busy) begin
        mem_busy = 1; mem_addr = imem_req_addr; mem_cnt = $urandom_range(lat_max, lat_min);
      end
    end
    if (id_valid === 1'b1 && id_ready) begin
      w = mem_word(exp_pc);
      n_assert++;
      if (id_pc !== exp_pc || id_instr !== w || id_op !== w[31:26]) begin
        n_fail++; $display("FAIL handshake: got %h@%h op %b want %h@%h op %b", id_instr, id_pc, id_op, w, exp_pc, w[31:26]);
      end
      pcs.push_back(id_pc);
      exp_pc  = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    prev_hold  = id_valid && !id_ready && !redirect_valid;
    hold_instr = id_instr;
    hold_pc    = id_pc;
  endtask

  task automatic settle_req();
    bit ok = 0;
    ready_pct = 0; idr_pct = 100; redir_pct = 0; stray_pct = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      if (imem_req_valid && !imem_req_ready && !mem_busy) ok = 1;
    end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL settle_timeout: reached REQ=0 want 1"); end
    idr_pct = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || imem_req_addr !== RESET_PC ||
        id_op !== 6'd0 || id_instr !== 32'd0 || id_pc !== 32'd0 || fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: req_v=%b id_v=%b addr=%h op=%b instr=%h pc=%h cnt=%0d want 0 0 %h 0 0 0 0",
               imem_req_valid, id_valid, imem_req_addr, id_op, id_instr, id_pc, fetch_cnt, RESET_PC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    ready_pct = 100; idr_pct = 0; lat_min = 1; lat_max = 1;
    cycle();
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL boot_cycle1: req_valid=%b addr=%h want 1 80000000", imem_req_valid, imem_req_addr);
    end
    cycle();
    n_assert++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_cycle2: req_valid=%b id_valid=%b want 0 0", imem_req_valid, id_valid);
    end
    cycle();
    n_assert++;
    if (id_valid !== 1'b1 || id_op !== 6'b100011 || id_pc !== 32'h8000_0000) begin
      n_fail++; $display("FAIL boot_cycle3: id_valid=%b op=%b pc=%h want 1 100011 80000000", id_valid, id_op, id_pc);
    end
  endtask

  task automatic test_sequential();
    pcs.delete();
    idr_pct = 100;
    for (int i = 0; i < 30 && exp_cnt < 3; i++) cycle();
    idr_pct = 0;
    cycle();
    n_assert++;
    if (fetch_cnt !== 32'd3 || pcs.size() != 3) begin
      n_fail++; $display("FAIL seq_count: fetch_cnt=%0d delivered=%0d want 3 3", fetch_cnt, pcs.size());
    end else begin
      n_assert++;
      if (pcs[0] !== 32'h8000_0000 || pcs[1] !== 32'h8000_0004 || pcs[2] !== 32'h8000_0008) begin
        n_fail++; $display("FAIL seq_addrs: got %h %h %h want 80000000 80000004 80000008", pcs[0], pcs[1], pcs[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held, hpc;
    bit ok = 0;
    ready_pct = 100; idr_pct = 0;
    for (int i = 0; i < 20 && !ok; i++) begin cycle(); ok = id_valid; end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: id_valid=0 want 1"); end
    held = id_instr; hpc = id_pc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_assert++;
      if (id_valid !== 1'b1 || id_instr !== held || imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall: id_valid=%b instr=%h req_valid=%b want 1 %h 0", id_valid, id_instr, imem_req_valid, held);
      end
    end
    idr_pct = 100;
    cycle();
    idr_pct = 0;
    cycle();
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== hpc + 32'd4) begin
      n_fail++; $display("FAIL bp_next_req: req_valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, hpc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit seen = 0, found = 0;
    settle_req();
    force_target = 32'h8000_0010; force_redir = 1;
    cycle();
    ready_pct = 100; lat_min = 3; lat_max = 3;
    cycle();
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010 || !mem_busy) begin
      n_fail++; $display("FAIL rw_req: req_valid=%b addr=%h want 1 80000010", imem_req_valid, imem_req_addr);
    end
    force_target = 32'h8000_0101; force_redir = 1; ready_pct = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (id_valid) seen = 1;
      if (imem_req_valid) found = 1;
    end
    n_assert++;
    if (seen || !found || mem_busy || imem_req_addr !== 32'h8000_0100) begin
      n_fail++; $display("FAIL rw_discard: id_seen=%b req_found=%b addr=%h want 0 1 80000100", seen, found, imem_req_addr);
    end
  endtask

  task automatic test_redirect_coincident();
    bit seen = 0, found = 0;
    logic [31:0] cnt0;
    settle_req();
    cnt0 = exp_cnt;
    ready_pct = 100; lat_min = 2; lat_max = 2;
    resp_target = 32'h8000_0203; redir_on_resp = 1;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      if (id_valid) seen = 1;
      if (!redir_on_resp && imem_req_valid) found = 1;
    end
    n_assert++;
    if (seen || !found || imem_req_addr !== 32'h8000_0200 || fetch_cnt !== cnt0) begin
      n_fail++; $display("FAIL rc_drop: id_seen=%b found=%b addr=%h cnt=%0d want 0 1 80000200 %0d", seen, found, imem_req_addr, fetch_cnt, cnt0);
    end
  endtask

  task automatic test_redirect_hold();
    bit ok = 0, seen = 0, found = 0;
    logic [31:0] cnt0;
    ready_pct = 100; idr_pct = 0; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 20 && !ok; i++) begin cycle(); ok = id_valid; end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL rh_timeout: id_valid=0 want 1"); end
    cnt0 = exp_cnt;
    force_target = 32'h0000_1000; force_redir = 1;
    cycle();
    n_assert++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid: id_valid=%b want 0", id_valid); end
    for (int i = 0; i < 5 && !found; i++) begin
      cycle();
      if (id_valid) seen = 1;
      if (imem_req_valid) found = 1;
    end
    n_assert++;
    if (seen || !found || imem_req_addr !== 32'h0000_1000 || fetch_cnt !== cnt0) begin
      n_fail++; $display("FAIL rh_drop: id_seen=%b found=%b addr=%h cnt=%0d want 0 1 00001000 %0d", seen, found, imem_req_addr, fetch_cnt, cnt0);
    end
  endtask

  task automatic test_wrap();
    bit ok = 0;
    settle_req();
    force_target = 32'hFFFF_FFFC; force_redir = 1;
    ready_pct = 100; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 20 && !ok; i++) begin cycle(); ok = id_valid; end
    n_assert++;
    if (!ok || id_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_hold: id_valid=%b pc=%h want 1 fffffffc", id_valid, id_pc);
    end
    idr_pct = 100;
    cycle();
    idr_pct = 0;
    cycle();
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_addr: req_valid=%b addr=%h want 1 00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_random();
    ready_pct = 60; idr_pct = 60; redir_pct = 6; stray_pct = 5; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) cycle();
    redir_pct = 0; stray_pct = 0;
  endtask

  task automatic test_async_reset();
    bit ok = 0, seen = 0;
    settle_req();
    ready_pct = 100; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 5 && !ok; i++) begin cycle(); ok = mem_busy; end
    ready_pct = 0;
    cycle();
    n_assert++;
    if (!ok || imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL ar_wait: accepted=%b req_valid=%b want 1 0", ok, imem_req_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || imem_req_addr !== RESET_PC ||
        id_op !== 6'd0 || id_pc !== 32'd0 || fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: req_v=%b id_v=%b addr=%h op=%b pc=%h cnt=%0d want 0 0 %h 0 0 0",
               imem_req_valid, id_valid, imem_req_addr, id_op, id_pc, fetch_cnt, RESET_PC);
    end
    #1 rst_n = 1'b1;
    exp_pc = RESET_PC; exp_cnt = 32'd0; prev_hold = 0; late_ok = 1;
    for (int i = 0; i < 8 && mem_busy; i++) begin
      cycle();
      if (id_valid) seen = 1;
    end
    cycle();
    if (id_valid) seen = 1;
    n_assert++;
    if (seen || mem_busy || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_fail++; $display("FAIL late_resp: id_seen=%b busy=%b req_valid=%b addr=%h want 0 0 1 %h", seen, mem_busy, imem_req_valid, imem_req_addr, RESET_PC);
    end
    late_ok = 0;
    pcs.delete();
    ready_pct = 100; idr_pct = 100; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 40 && exp_cnt < 2; i++) cycle();
    n_assert++;
    if (pcs.size() < 2 || pcs[0] !== RESET_PC) begin
      n_fail++; $display("FAIL post_reset_fetch: delivered=%0d want >=2 starting at %h", pcs.size(), RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_redirect_hold();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage directly upstream of the main decoder. It holds the program counter and issues one word-aligned read at a time to instruction memory over a valid/ready request channel. It buffers the returned word and presents it to decode with a valid/ready handshake, exposing `instr[31:26]` as the decoder opcode. It also accepts PC redirects from branch/jump resolution (BEQ, BLEZ, J) and discards any fetch that a redirect makes stale.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output 32: fetch address; always equals the PC register.
- `imem_resp_valid` input 1: read data valid. Only meaningful while a request is outstanding.
- `imem_resp_data` input 32: instruction word.
- `redirect_valid` input 1: next PC override from branch/jump logic.
- `redirect_pc` input 32: redirect target; bits [1:0] are forced to 0 internally.
- `id_valid` output 1: instruction available to decode.
- `id_ready` input 1: decode consumes the instruction.
- `id_instr` output 32: buffered instruction word.
- `id_pc` output 32: address of `id_instr`.
- `id_op` output 6: `id_instr[31:26]`, wired to the decoder `op` input.
- `fetch_cnt` output 32: count of instructions handed to decode; wraps modulo 2^32.

## Operation
- **State machine:** four states, IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- **IDLE:** goes to REQ unconditionally on the next edge. Makes no request.
- **REQ:**
  - `imem_req_valid = (state==REQ) && !redirect_valid`.
  - If `redirect_valid`: pc <= {redirect_pc[31:2],2'b00}; stay in REQ.
  - Else if `imem_req_ready`: go to WAIT. The pc register is unchanged and remains the address of the outstanding fetch.
- **WAIT:** one request is outstanding; no new request is issued.
  - If `redirect_valid`: pc <= redirect target, kill <= 1. A response arriving in the same cycle is discarded and the state goes to REQ.
  - Else if `imem_resp_valid && !kill`: buf_instr <= imem_resp_data, buf_pc <= pc; go to HOLD.
  - Else if `imem_resp_valid && kill`: discard the response, kill <= 0, go to REQ.
- **HOLD:**
  - `id_valid = (state==HOLD) && !redirect_valid`.
  - If `redirect_valid`: drop the buffer, pc <= redirect target, go to REQ. This is not counted as a handshake.
  - Else if `id_ready`: pc <= buf_pc + 32'd4 (wraps modulo 2^32), `fetch_cnt` += 1, go to REQ.
- **Kill flag:**
  - Set only in WAIT.
  - Cleared when the stale response is absorbed, or when a redirect arrives in the same cycle as the response (state leaves WAIT).
  - A second redirect while kill=1 only updates pc.
- **Protocol violation:** `imem_resp_valid` in IDLE, REQ or HOLD is ignored with no state change.
- **Output hold:** `id_instr`/`id_pc`/`id_op` are driven from buf registers and stay stable while `id_valid` is high and `id_ready` is low.

## Timing
- **Reset values** (asserted asynchronously while `rst_n`=0):
  - state=IDLE, pc=RESET_PC, kill=0.
  - buf_instr=0, buf_pc=0, fetch_cnt=0.
  - `imem_req_valid`=0, `id_valid`=0, `imem_req_addr`=RESET_PC, `id_op`=0.
- **Reset release:** with `rst_n` rising before edge 0, `imem_req_valid`=1 in cycle 1.
- **Latency:**
  - Request accepted in cycle N, response in cycle N+k (k>=1): `id_valid`=1 in cycle N+k+1.
  - Handshake with decode in cycle M: next request is valid in cycle M+1.
  - Best-case throughput is one instruction per 3 cycles (request, response, decode handshake).
- **Reset mid-operation:** returns to IDLE immediately. An outstanding memory response arriving after reset release is ignored, because state is not WAIT.
- Redirect has priority over every other event in every state. No combinational path exists from `imem_resp_*` to any output.

## Test plan
- **Reset/boot:** release reset with memory ready and 1-cycle latency returning 32'h8C010004 (LW) → cycle 1 req addr 8000_0000; cycle 3 `id_valid`=1, `id_op`=6'b100011, `id_pc`=8000_0000.
- **Sequential fetch:** decode always ready, memory returns 3 words → addresses 8000_0000, 8000_0004, 8000_0008; `fetch_cnt`=3 afterwards.
- **Backpressure:** hold `id_ready`=0 for 5 cycles in HOLD → `id_instr` stable; no new request. Raise `id_ready` → next request at pc+4 the following cycle.
- **Redirect in WAIT:** request at 8000_0010 accepted; redirect to 8000_0101 the next cycle. The response 2 cycles later is discarded and never shown on `id_valid`. Next request address is 8000_0100.
- **Redirect with response coincident, and redirect in HOLD:** in both cases the word is dropped, `fetch_cnt` is unchanged, and the next request is at the target.
- **Wrap and async reset:** buf_pc=FFFF_FFFC plus handshake → next addr 0000_0000. Pulse `rst_n` low mid-WAIT → outputs at reset values without a clock edge, and a late response is ignored.
